wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between four writers: ALU (req 0), LSU load return (req 1), MUL/DIV unit (req 2) and the JTAG debug writer.
- Each core writer uses a valid/ready handshake. The JTAG writer is serviced only in idle cycles.
- The arbiter registers the winning write and drives the register file's we_i/waddr_i/wdata_i directly, so the file's same-cycle read bypass sees the registered write.
- A starvation guard stops back-to-back ALU writes from locking out LSU/MDU results indefinitely.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- STARVE_LIMIT, 4, consecutive blocked cycles before LSU/MDU overrides ALU priority. Must be >= 1.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU write request
- alu_addr_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU write data
- alu_ready_o  out  1  ALU request accepted this cycle
- lsu_valid_i / lsu_addr_i / lsu_data_i / lsu_ready_o  same widths  LSU load-return write
- mdu_valid_i / mdu_addr_i / mdu_data_i / mdu_ready_o  same widths  MUL/DIV write
- jtag_we_i  in  1  JTAG write request
- jtag_addr_i  in  ADDR_W  JTAG destination register
- jtag_data_i  in  DATA_W  JTAG write data
- jtag_ready_o  out  1  JTAG write accepted this cycle
- we_o  out  1  register-file write enable
- waddr_o  out  ADDR_W  register-file write address
- wdata_o  out  DATA_W  register-file write data
- starve_o  out  1  a starvation override is active this cycle (debug/perf)

Behaviour:
- Reset, asynchronous on rst low:
  - we_o, waddr_o, wdata_o = 0.
  - rr_q = 0.
  - Both wait counters = 0.
  - All ready outputs are forced 0 while rst is low (combinational gating).
- Transfer occurs when valid && ready in the same cycle.
- Requesters hold valid, addr and data stable until accepted. The arbiter does not require this but never drops a held request.
- Grant is combinational from the current valids and state. At most one ready is high per cycle.
- Priority, highest first:
  1. A starved LSU/MDU requester.
  2. ALU.
  3. LSU/MDU by round-robin.
  4. JTAG.
- Round-robin:
  - rr_q = 0 favours LSU; rr_q = 1 favours MDU.
  - After any LSU grant, rr_q <= 1. After any MDU grant, rr_q <= 0.
  - rr_q is otherwise unchanged, including on ALU or JTAG grants.
- Wait counters (LSU and MDU, each $clog2(STARVE_LIMIT+1) bits):
  - Increment when valid && !ready, saturating at STARVE_LIMIT.
  - Clear to 0 on a grant to that requester, or when its valid is low.
- Starvation:
  - A requester is starved when its counter == STARVE_LIMIT and valid is high.
  - A starved requester beats ALU, so alu_ready_o = 0 that cycle.
  - If both LSU and MDU are starved, rr_q picks between them.
  - starve_o = 1 in any cycle where an override grant is issued.
- JTAG:
  - jtag_ready_o = jtag_we_i && no core valid is high.
  - JTAG never preempts and has no starvation guard. Debug writes are issued with the core halted.
- Output register, 1-cycle latency:
  - On a transfer, waddr_o <= addr and wdata_o <= data.
  - we_o <= 1 only if addr != 0. A write to x0 is accepted (ready = 1) but produces we_o = 0.
  - With no transfer, we_o <= 0. waddr_o and wdata_o hold their previous values.
- Simultaneous events:
  - A request accepted in cycle N appears on we_o in cycle N+1.
  - A new grant in cycle N+1 does not disturb the cycle-N output.
  - Sustained throughput is one write per cycle.
- Reset mid-operation: any pending un-accepted requests are simply not granted, and counters and rr_q restart from 0. A write that has been accepted but is not yet visible on we_o is lost. It is up to the pipeline to flush on reset.

Test Plan:
- Reset: drive rst low with all valids high -> all readies 0, we_o = 0. Release rst with only alu_valid_i, addr 5, data 0x1234 -> alu_ready_o = 1; next cycle we_o = 1, waddr_o = 5, wdata_o = 0x1234.
- Round-robin: LSU (addr 3) and MDU (addr 4) held valid, ALU idle, from reset -> grants LSU, then MDU, then LSU, alternating. rr_q toggles each grant; starve_o stays 0.
- Starvation: ALU valid every cycle, LSU valid from cycle 0, STARVE_LIMIT = 4 -> ALU granted cycles 0–3, LSU granted in cycle 4 with starve_o = 1 and alu_ready_o = 0, ALU resumes in cycle 5.
- x0 filtering: ALU write to addr 0, data 0xFFFF_FFFF -> alu_ready_o = 1, next cycle we_o = 0. JTAG write to addr 0 behaves the same.
- JTAG: jtag_we_i held with an MDU request pending for 2 cycles -> jtag_ready_o = 0 for those 2 cycles, then 1 in the first cycle with no core valid. The output then writes the JTAG addr/data.
- Async reset mid-burst: drop rst low between clock edges while LSU is at wait count 3 -> we_o clears immediately. After release, LSU needs the full 4 blocked cycles again before an override.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: three core valid/ready writers, a JTAG writer,
// and the registered write port driven into the register file.
interface wb_port_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              alu_valid_i;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_ready_o;
  logic              lsu_valid_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              lsu_ready_o;
  logic              mdu_valid_i;
  logic [ADDR_W-1:0] mdu_addr_i;
  logic [DATA_W-1:0] mdu_data_i;
  logic              mdu_ready_o;
  logic              jtag_we_i;
  logic [ADDR_W-1:0] jtag_addr_i;
  logic [DATA_W-1:0] jtag_data_i;
  logic              jtag_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              starve_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  mdu_valid_i, mdu_addr_i, mdu_data_i,
    input  jtag_we_i, jtag_addr_i, jtag_data_i,
    output alu_ready_o, lsu_ready_o, mdu_ready_o, jtag_ready_o,
    output we_o, waddr_o, wdata_o, starve_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    output mdu_valid_i, mdu_addr_i, mdu_data_i,
    output jtag_we_i, jtag_addr_i, jtag_data_i,
    input  alu_ready_o, lsu_ready_o, mdu_ready_o, jtag_ready_o,
    input  we_o, waddr_o, wdata_o, starve_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU, LSU, MDU and JTAG,
// with LSU/MDU round-robin, a starvation override against ALU, and a registered write.
module wb_port_arbiter #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    RR_LSU = 1'b0,
    RR_MDU = 1'b1
  } rr_t;

  rr_t               r_rr;
  logic [CNT_W-1:0]  r_lsu_wait;
  logic [CNT_W-1:0]  r_mdu_wait;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_lsu_starved;
  logic              w_mdu_starved;
  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_mdu_gnt;
  logic              w_jtag_gnt;
  logic              w_starve;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_lsu_starved = bus.lsu_valid_i && (r_lsu_wait == LIMIT);
  assign w_mdu_starved = bus.mdu_valid_i && (r_mdu_wait == LIMIT);

  // Readies are gated by rst so nothing is accepted while reset is asserted.
  always_comb begin
    w_alu_gnt  = 1'b0;
    w_lsu_gnt  = 1'b0;
    w_mdu_gnt  = 1'b0;
    w_jtag_gnt = 1'b0;
    w_starve   = 1'b0;
    if (rst) begin
      if (w_lsu_starved && w_mdu_starved) begin
        w_starve = 1'b1;
        if (r_rr == RR_LSU) w_lsu_gnt = 1'b1;
        else                w_mdu_gnt = 1'b1;
      end else if (w_lsu_starved) begin
        w_starve  = 1'b1;
        w_lsu_gnt = 1'b1;
      end else if (w_mdu_starved) begin
        w_starve  = 1'b1;
        w_mdu_gnt = 1'b1;
      end else if (bus.alu_valid_i) begin
        w_alu_gnt = 1'b1;
      end else if (bus.lsu_valid_i && bus.mdu_valid_i) begin
        if (r_rr == RR_LSU) w_lsu_gnt = 1'b1;
        else                w_mdu_gnt = 1'b1;
      end else if (bus.lsu_valid_i) begin
        w_lsu_gnt = 1'b1;
      end else if (bus.mdu_valid_i) begin
        w_mdu_gnt = 1'b1;
      end else if (bus.jtag_we_i) begin
        w_jtag_gnt = 1'b1;
      end
    end
  end

  assign w_xfer = w_alu_gnt || w_lsu_gnt || w_mdu_gnt || w_jtag_gnt;

  always_comb begin
    w_addr = bus.jtag_addr_i;
    w_data = bus.jtag_data_i;
    if (w_alu_gnt) begin
      w_addr = bus.alu_addr_i;
      w_data = bus.alu_data_i;
    end else if (w_lsu_gnt) begin
      w_addr = bus.lsu_addr_i;
      w_data = bus.lsu_data_i;
    end else if (w_mdu_gnt) begin
      w_addr = bus.mdu_addr_i;
      w_data = bus.mdu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr       <= RR_LSU;
      r_lsu_wait <= '0;
      r_mdu_wait <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      if (bus.lsu_valid_i && !w_lsu_gnt) begin
        if (r_lsu_wait != LIMIT) r_lsu_wait <= r_lsu_wait + CNT_W'(1);
      end else begin
        r_lsu_wait <= '0;
      end

      if (bus.mdu_valid_i && !w_mdu_gnt) begin
        if (r_mdu_wait != LIMIT) r_mdu_wait <= r_mdu_wait + CNT_W'(1);
      end else begin
        r_mdu_wait <= '0;
      end

      if (w_lsu_gnt)      r_rr <= RR_MDU;
      else if (w_mdu_gnt) r_rr <= RR_LSU;

      // Writes to x0 are accepted but never reach the register file.
      if (w_xfer) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
        r_we    <= (w_addr != '0);
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  assign bus.alu_ready_o  = w_alu_gnt;
  assign bus.lsu_ready_o  = w_lsu_gnt;
  assign bus.mdu_ready_o  = w_mdu_gnt;
  assign bus.jtag_ready_o = w_jtag_gnt;
  assign bus.starve_o     = w_starve;
  assign bus.we_o         = r_we;
  assign bus.waddr_o      = r_waddr;
  assign bus.wdata_o      = r_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: single-cycle grant table plus multi-cycle
// round-robin, starvation, JTAG and async-reset sequences with an output scoreboard.
module tb_wb_port_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } out_t;

  // rdy/v bit order: {jtag, mdu, lsu, alu}; each source drives data + its index
  typedef struct {
    string             name;
    logic [3:0]        v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        rdy;
  } vec_t;

  int unsigned       n_checks = 0;
  int unsigned       n_fail   = 0;
  out_t              sb[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.alu_valid_i = v[0]; bus.alu_addr_i  = a; bus.alu_data_i  = d;
    bus.lsu_valid_i = v[1]; bus.lsu_addr_i  = a; bus.lsu_data_i  = d + 32'd1;
    bus.mdu_valid_i = v[2]; bus.mdu_addr_i  = a; bus.mdu_data_i  = d + 32'd2;
    bus.jtag_we_i   = v[3]; bus.jtag_addr_i = a; bus.jtag_data_i = d + 32'd3;
  endtask

  function automatic logic [3:0] readies();
    return {bus.jtag_ready_o, bus.mdu_ready_o, bus.lsu_ready_o, bus.alu_ready_o};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    drive(4'b1111, 5'd1, 32'h55);
    #1;
    chk("rst_readies", 64'(readies()), 64'(4'b0000));
    chk("rst_we", 64'(bus.we_o), 64'(1'b0));
    chk("rst_waddr", 64'(bus.waddr_o), 64'(0));
    chk("rst_wdata", 64'(bus.wdata_o), 64'(0));
    chk("rst_starve", 64'(bus.starve_o), 64'(1'b0));
    @(posedge clk); #1;
    chk("rst_readies_edge", 64'(readies()), 64'(4'b0000));
    drive(4'b0000, '0, '0);
    rst = 1'b1;
    exp_addr = '0;
    exp_data = '0;
    sb.delete();
  endtask

  // Inputs are already set; check grant, queue the expected write, clock, compare.
  task automatic cycle(input string nm, input logic [3:0] exp_rdy, input logic exp_st);
    out_t              e;
    out_t              got;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    #1;
    chk({nm, "_rdy"}, 64'(readies()), 64'(exp_rdy));
    chk({nm, "_starve"}, 64'(bus.starve_o), 64'(exp_st));
    a = exp_addr;
    d = exp_data;
    if (exp_rdy == 4'b0001)      begin a = bus.alu_addr_i;  d = bus.alu_data_i;  end
    else if (exp_rdy == 4'b0010) begin a = bus.lsu_addr_i;  d = bus.lsu_data_i;  end
    else if (exp_rdy == 4'b0100) begin a = bus.mdu_addr_i;  d = bus.mdu_data_i;  end
    else if (exp_rdy == 4'b1000) begin a = bus.jtag_addr_i; d = bus.jtag_data_i; end
    e.we   = (exp_rdy != 4'b0000) && (a != '0);
    e.addr = a;
    e.data = d;
    exp_addr = a;
    exp_data = d;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      got = sb.pop_front();
      chk({nm, "_we"}, 64'(bus.we_o), 64'(got.we));
      chk({nm, "_waddr"}, 64'(bus.waddr_o), 64'(got.addr));
      chk({nm, "_wdata"}, 64'(bus.wdata_o), 64'(got.data));
    end
  endtask

  task automatic starve_seq(input string nm);
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd7; bus.alu_data_i = 32'h77;
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd3; bus.lsu_data_i = 32'h33;
    for (int i = 0; i < 4; i++) cycle({nm, "_alu"}, 4'b0001, 1'b0);
    cycle({nm, "_override"}, 4'b0010, 1'b1);
    bus.lsu_valid_i = 1'b0;
    cycle({nm, "_alu_resume"}, 4'b0001, 1'b0);
    bus.alu_valid_i = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"alu_only",    4'b0001, 5'd5,  32'h0000_1234, 4'b0001};
    vecs[1]  = '{"lsu_only",    4'b0010, 5'd3,  32'h0000_0300, 4'b0010};
    vecs[2]  = '{"mdu_only",    4'b0100, 5'd4,  32'h0000_0400, 4'b0100};
    vecs[3]  = '{"all_core",    4'b0111, 5'd6,  32'h0000_0600, 4'b0001};
    vecs[4]  = '{"lsu_mdu_rr0", 4'b0110, 5'd8,  32'h0000_0800, 4'b0010};
    vecs[5]  = '{"jtag_only",   4'b1000, 5'd9,  32'h0000_0900, 4'b1000};
    vecs[6]  = '{"jtag_alu",    4'b1001, 5'd10, 32'h0000_0A00, 4'b0001};
    vecs[7]  = '{"jtag_lsu",    4'b1010, 5'd11, 32'h0000_0B00, 4'b0010};
    vecs[8]  = '{"idle",        4'b0000, 5'd12, 32'h0000_0C00, 4'b0000};
    vecs[9]  = '{"alu_x0",      4'b0001, 5'd0,  32'hFFFF_FFFF, 4'b0001};
    vecs[10] = '{"jtag_x0",     4'b1000, 5'd0,  32'hFFFF_FFFC, 4'b1000};
    vecs[11] = '{"all_four",    4'b1111, 5'd31, 32'hDEAD_0000, 4'b0001};

    drive(4'b0000, '0, '0);
    #2;
    for (int unsigned i = 0; i < 12; i++) begin
      do_reset();
      drive(vecs[i].v, vecs[i].addr, vecs[i].data);
      cycle(vecs[i].name, vecs[i].rdy, 1'b0);
      drive(4'b0000, '0, '0);
      cycle({vecs[i].name, "_after"}, 4'b0000, 1'b0);
    end

    // LSU/MDU alternate under round-robin
    do_reset();
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd3; bus.lsu_data_i = 32'h300;
    bus.mdu_valid_i = 1'b1; bus.mdu_addr_i = 5'd4; bus.mdu_data_i = 32'h400;
    for (int i = 0; i < 3; i++) begin
      cycle("rr_lsu", 4'b0010, 1'b0);
      cycle("rr_mdu", 4'b0100, 1'b0);
    end
    drive(4'b0000, '0, '0);

    do_reset();
    starve_seq("starve");

    // JTAG waits out two MDU writes, then takes the idle cycle
    do_reset();
    bus.jtag_we_i = 1'b1; bus.jtag_addr_i = 5'd9; bus.jtag_data_i = 32'h900;
    bus.mdu_valid_i = 1'b1; bus.mdu_addr_i = 5'd4; bus.mdu_data_i = 32'h44;
    cycle("jtag_blk0", 4'b0100, 1'b0);
    bus.mdu_data_i = 32'h45;
    cycle("jtag_blk1", 4'b0100, 1'b0);
    bus.mdu_valid_i = 1'b0;
    cycle("jtag_go", 4'b1000, 1'b0);
    bus.jtag_we_i = 1'b0;
    cycle("jtag_done", 4'b0000, 1'b0);

    // Async reset mid-burst with the LSU wait count at 3
    do_reset();
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd7; bus.alu_data_i = 32'h77;
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd3; bus.lsu_data_i = 32'h33;
    for (int i = 0; i < 3; i++) cycle("burst_alu", 4'b0001, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_we", 64'(bus.we_o), 64'(1'b0));
    chk("async_waddr", 64'(bus.waddr_o), 64'(0));
    chk("async_readies", 64'(readies()), 64'(4'b0000));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_addr = '0;
    exp_data = '0;
    sb.delete();
    starve_seq("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
